// File: rtl/otp_pkg.sv
// Shared types for the OTP program sequencer and the array controller FSM.
package otp_pkg;

    // Controller operating mode, shared with the array controller FSM.
    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_PROG = 2'd1,
        MODE_READ = 2'd2
    } mode_t;

    // Sequencer control states.
    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StProg = 3'd1,
        StRead = 3'd2,
        StCmp  = 3'd3,
        StAck  = 3'd4,
        StDone = 3'd5,
        StFail = 3'd6
    } seq_state_t;

    // Largest of three counts; sizes the shared cycle counters.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/otp_cycle_counter.sv
// Loadable down-counter with a zero flag; saturates at zero.
module otp_cycle_counter
    import otp_pkg::*;
#(
    parameter int unsigned WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/otp_program_sequencer.sv
// Programs one host word into the OTP array column by column, with read-verify and retry.
module otp_program_sequencer
    import otp_pkg::*;
#(
    parameter int unsigned A            = 2,
    parameter int unsigned B            = 2,
    parameter int unsigned PROG_CYCLES  = 8,
    parameter int unsigned READ_CYCLES  = 2,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned READ_TIMEOUT = 16,
    localparam int unsigned ADDR_WIDTH  = (B > 1) ? $clog2(B) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [A*B-1:0]        cmd_word,
    output mode_t                 mode,
    output logic [ADDR_WIDTH-1:0] column,
    output logic [A-1:0]          data_in,
    output logic                  writing_successful,
    input  logic                  read_active,
    input  logic [A-1:0]          data_out,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_column
);

    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned CNT_W   = $clog2(max3(PROG_CYCLES, READ_CYCLES, READ_TIMEOUT) + 1);

    localparam logic [ADDR_WIDTH-1:0] LAST_COL  = ADDR_WIDTH'(B - 1);
    localparam logic [RETRY_W-1:0]    RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [CNT_W-1:0]      PROG_LOAD = CNT_W'(PROG_CYCLES - 1);
    localparam logic [CNT_W-1:0]      TOUT_LOAD = CNT_W'(READ_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]      HIGH_LOAD = CNT_W'(READ_CYCLES - 1);

    seq_state_t            r_state, w_state_nxt;
    logic [A*B-1:0]        r_word, w_word_nxt;
    logic [ADDR_WIDTH-1:0] r_col, w_col_nxt;
    logic [RETRY_W-1:0]    r_retry, w_retry_nxt;
    logic [A-1:0]          r_capt, w_capt_nxt;
    logic                  r_pass, w_pass_nxt;
    logic [ADDR_WIDTH-1:0] r_fail_col, w_fail_col_nxt;

    logic [A-1:0]          w_slice;
    logic                  w_slice_zero;
    logic                  w_verified;
    logic                  w_load_prog;
    logic                  w_load_read;
    logic                  w_main_load;
    logic [CNT_W-1:0]      w_main_val;
    logic                  w_main_dec;
    logic                  w_main_zero;
    logic [CNT_W-1:0]      w_main_count;
    logic                  w_high_load;
    logic                  w_high_dec;
    logic                  w_high_zero;
    logic [CNT_W-1:0]      w_high_count;

    assign w_slice      = r_word[r_col*A +: A];
    assign w_slice_zero = (w_slice == '0);
    // OTP bits only go 0->1, so extra ones read back are harmless.
    assign w_verified   = ((r_capt & w_slice) == w_slice);

    // Main counter times the program pulse, then the read_active timeout.
    assign w_main_load = w_load_prog | w_load_read;
    assign w_main_val  = w_load_prog ? PROG_LOAD : TOUT_LOAD;
    assign w_main_dec  = ((r_state == StProg) && !w_slice_zero) ||
                         ((r_state == StRead) && !read_active);

    // High counter measures consecutive read_active cycles; any low cycle restarts it.
    assign w_high_load = w_load_read || ((r_state == StRead) && !read_active);
    assign w_high_dec  = (r_state == StRead) && read_active;

    otp_cycle_counter #(
        .WIDTH(CNT_W)
    ) u_main_cnt (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_load     (w_main_load),
        .i_load_val (w_main_val),
        .i_dec      (w_main_dec),
        .o_count    (w_main_count),
        .o_zero     (w_main_zero)
    );

    otp_cycle_counter #(
        .WIDTH(CNT_W)
    ) u_high_cnt (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_load     (w_high_load),
        .i_load_val (HIGH_LOAD),
        .i_dec      (w_high_dec),
        .o_count    (w_high_count),
        .o_zero     (w_high_zero)
    );

    // State and datapath registers; reset aborts any command in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_word     <= '0;
            r_col      <= '0;
            r_retry    <= '0;
            r_capt     <= '0;
            r_pass     <= 1'b0;
            r_fail_col <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_word     <= w_word_nxt;
            r_col      <= w_col_nxt;
            r_retry    <= w_retry_nxt;
            r_capt     <= w_capt_nxt;
            r_pass     <= w_pass_nxt;
            r_fail_col <= w_fail_col_nxt;
        end
    end

    // Next-state, datapath updates and FSM-facing outputs.
    always_comb begin
        w_state_nxt        = r_state;
        w_word_nxt         = r_word;
        w_col_nxt          = r_col;
        w_retry_nxt        = r_retry;
        w_capt_nxt         = r_capt;
        w_pass_nxt         = r_pass;
        w_fail_col_nxt     = r_fail_col;
        w_load_prog        = 1'b0;
        w_load_read        = 1'b0;
        mode               = MODE_IDLE;
        data_in            = '0;
        writing_successful = 1'b0;
        done               = 1'b0;
        cmd_ready          = 1'b0;

        unique case (r_state)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_word_nxt  = cmd_word;
                    w_col_nxt   = '0;
                    w_retry_nxt = '0;
                    w_load_prog = 1'b1;
                    w_state_nxt = StProg;
                end
            end
            StProg: begin
                if (w_slice_zero) begin
                    // Nothing to burn in this column: move on without a pulse.
                    if (r_col == LAST_COL) begin
                        w_pass_nxt  = 1'b1;
                        w_state_nxt = StDone;
                    end else begin
                        w_col_nxt   = r_col + ADDR_WIDTH'(1);
                        w_retry_nxt = '0;
                        w_load_prog = 1'b1;
                    end
                end else begin
                    mode    = MODE_PROG;
                    data_in = w_slice;
                    if (w_main_zero) begin
                        w_load_read = 1'b1;
                        w_state_nxt = StRead;
                    end
                end
            end
            StRead: begin
                mode = MODE_READ;
                if (read_active) begin
                    if (w_high_zero) begin
                        w_capt_nxt  = data_out;
                        w_state_nxt = StCmp;
                    end
                end else if (w_main_zero) begin
                    w_pass_nxt     = 1'b0;
                    w_fail_col_nxt = r_col;
                    w_state_nxt    = StFail;
                end
            end
            StCmp: begin
                if (w_verified) begin
                    w_state_nxt = StAck;
                end else if (r_retry < RETRY_MAX) begin
                    w_retry_nxt = r_retry + RETRY_W'(1);
                    w_load_prog = 1'b1;
                    w_state_nxt = StProg;
                end else begin
                    w_pass_nxt     = 1'b0;
                    w_fail_col_nxt = r_col;
                    w_state_nxt    = StFail;
                end
            end
            StAck: begin
                writing_successful = 1'b1;
                if (r_col == LAST_COL) begin
                    w_pass_nxt  = 1'b1;
                    w_state_nxt = StDone;
                end else begin
                    w_col_nxt   = r_col + ADDR_WIDTH'(1);
                    w_retry_nxt = '0;
                    w_load_prog = 1'b1;
                    w_state_nxt = StProg;
                end
            end
            StDone: begin
                done        = 1'b1;
                w_state_nxt = StIdle;
            end
            StFail: begin
                done        = 1'b1;
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign column      = r_col;
    assign pass        = r_pass;
    assign fail_column = r_fail_col;

endmodule
